ram_upload_responder: RTL and testbench

- Serves HPS-initiated ioctl uploads by reading a window of core work RAM and returning it byte-by-byte on ioctl_din. It is the read-back counterpart of the ioctl download path.
- Pauses the CPU for the duration of an upload and arbitrates single-byte RAM reads through a req/ack handshake.
- Tracks writes into the window and raises ioctl_upload_req once the data has been stable for a set number of frames (autosave).
- Sits beside hps_io and the hiscore/pause logic in the emu top level, clocked by clk_49m.

---
 rtl/ram_upload_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_ram_upload_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_upload_responder.sv
// Upload responder: answers HPS ioctl uploads for one index by reading a window
// of core work RAM byte-by-byte, pausing the CPU while the upload runs, and
// requesting an autosave upload once written data has been stable for a while.
module ram_upload_responder #(
    parameter int unsigned          ADDR_W        = 16,
    parameter logic [ADDR_W-1:0]    REGION_BASE   = '0,
    parameter int unsigned          REGION_LEN    = 256,
    parameter logic [7:0]           UPLOAD_INDEX  = 8'd4,
    parameter logic [7:0]           STABLE_FRAMES = 8'd60,
    parameter logic [7:0]           ACK_TIMEOUT   = 8'd255
) (
    input  logic              clk_49m,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic [24:0]       ioctl_addr,
    input  logic              ioctl_rd,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              ioctl_upload_req,
    input  logic              autosave,
    input  logic              vblank,
    input  logic              ram_wr_seen,
    output logic              pause_req,
    input  logic              paused,
    output logic              ram_req,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_data,
    input  logic              ram_ack,
    output logic              timeout_err
);

    typedef enum logic [2:0] {IDLE, PAUSING, READY, FETCH, DRAIN} state_t;

    state_t            state_q;
    logic              active_q;
    logic              vblank_q;
    logic              wait_q;
    logic              pause_req_q;
    logic              ram_req_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [7:0]        din_q;
    logic              timeout_q;
    logic [7:0]        tmo_q;
    logic              pend_q;
    logic [24:0]       pend_addr_q;
    logic              upload_req_q;
    logic              dirty_q;
    logic              issued_q;
    logic              wr_during_q;
    logic              was_idle_q;
    logic [7:0]        frame_q;

    logic        active;
    logic        start;
    logic        vb_rise;
    logic        rd_any;
    logic [24:0] rd_addr;
    logic        in_range;
    logic        upload_end;
    logic        tmo_hit;

    assign active     = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign start      = active && !active_q;
    assign vb_rise    = vblank && !vblank_q;
    // A read captured while pausing is served as soon as the pause completes.
    assign rd_any     = ioctl_rd || pend_q;
    assign rd_addr    = ioctl_rd ? ioctl_addr : pend_addr_q;
    assign in_range   = ({7'd0, rd_addr} < REGION_LEN);
    assign upload_end = (state_q == IDLE) && !was_idle_q;
    assign tmo_hit    = (tmo_q == ACK_TIMEOUT - 8'd1);

    assign ioctl_din        = din_q;
    assign ioctl_wait       = wait_q || (active && ioctl_rd);
    assign ioctl_upload_req = upload_req_q;
    assign pause_req        = pause_req_q;
    assign ram_req          = ram_req_q;
    assign ram_addr         = ram_addr_q;
    assign timeout_err      = timeout_q;

    // Edge-detect history for upload activity and vblank.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            active_q <= active;
            vblank_q <= vblank;
        end
    end

    // Upload FSM: pause handshake, byte fetch with timeout, drain on early end.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_q      <= 1'b0;
            pause_req_q <= 1'b0;
            ram_req_q   <= 1'b0;
            ram_addr_q  <= '0;
            din_q       <= 8'h00;
            timeout_q   <= 1'b0;
            tmo_q       <= 8'd0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wait_q      <= 1'b0;
                    ram_req_q   <= 1'b0;
                    pause_req_q <= 1'b0;
                    pend_q      <= 1'b0;
                    if (start) begin
                        state_q     <= PAUSING;
                        pause_req_q <= 1'b1;
                        timeout_q   <= 1'b0;
                    end
                end
                PAUSING: begin
                    if (!active) begin
                        state_q     <= IDLE;
                        pause_req_q <= 1'b0;
                        wait_q      <= 1'b0;
                        pend_q      <= 1'b0;
                    end else begin
                        if (ioctl_rd) begin
                            pend_q      <= 1'b1;
                            pend_addr_q <= ioctl_addr;
                            wait_q      <= 1'b1;
                        end
                        if (paused) begin
                            pend_q  <= 1'b0;
                            state_q <= READY;
                            if (rd_any) begin
                                if (in_range) begin
                                    state_q    <= FETCH;
                                    ram_req_q  <= 1'b1;
                                    ram_addr_q <= REGION_BASE + rd_addr[ADDR_W-1:0];
                                    tmo_q      <= 8'd0;
                                    wait_q     <= 1'b1;
                                end else begin
                                    din_q  <= 8'hFF;
                                    wait_q <= 1'b0;
                                end
                            end
                        end
                    end
                end
                READY: begin
                    if (!active) begin
                        state_q     <= IDLE;
                        pause_req_q <= 1'b0;
                    end else if (ioctl_rd) begin
                        if (in_range) begin
                            state_q    <= FETCH;
                            ram_req_q  <= 1'b1;
                            ram_addr_q <= REGION_BASE + rd_addr[ADDR_W-1:0];
                            tmo_q      <= 8'd0;
                            wait_q     <= 1'b1;
                        end else begin
                            din_q <= 8'hFF;
                        end
                    end
                end
                FETCH, DRAIN: begin
                    if (ram_ack || tmo_hit) begin
                        din_q     <= ram_ack ? ram_data : 8'h00;
                        timeout_q <= timeout_q || !ram_ack;
                        ram_req_q <= 1'b0;
                        wait_q    <= 1'b0;
                        if (active && state_q == FETCH) begin
                            state_q <= READY;
                        end else begin
                            state_q     <= IDLE;
                            pause_req_q <= 1'b0;
                        end
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                        if (!active) begin
                            state_q <= DRAIN;
                            wait_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Dirty tracking and the stable-frames autosave request.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            upload_req_q <= 1'b0;
            dirty_q      <= 1'b0;
            issued_q     <= 1'b0;
            wr_during_q  <= 1'b0;
            was_idle_q   <= 1'b1;
            frame_q      <= 8'd0;
        end else begin
            upload_req_q <= 1'b0;
            was_idle_q   <= (state_q == IDLE);
            if (state_q != IDLE && ram_wr_seen) begin
                wr_during_q <= 1'b1;
            end
            if (upload_end) begin
                dirty_q     <= wr_during_q || ram_wr_seen;
                issued_q    <= 1'b0;
                frame_q     <= 8'd0;
                wr_during_q <= 1'b0;
            end else if (ram_wr_seen) begin
                dirty_q  <= 1'b1;
                frame_q  <= 8'd0;
                issued_q <= 1'b0;
            end else if (!autosave) begin
                frame_q <= 8'd0;
            end else if (state_q == IDLE && dirty_q && !issued_q && vb_rise) begin
                if (frame_q == STABLE_FRAMES - 8'd1) begin
                    upload_req_q <= 1'b1;
                    issued_q     <= 1'b1;
                    frame_q      <= 8'd0;
                end else if (frame_q != 8'hFF) begin
                    frame_q <= frame_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_upload_responder.sv
// Directed bench for ram_upload_responder: uploads, out-of-range reads,
// ack timeout, early upload end and autosave request timing.
module tb_ram_upload_responder;

    logic        clk;
    logic        rst_n;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic        ioctl_rd;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        ioctl_upload_req;
    logic        autosave;
    logic        vblank;
    logic        ram_wr_seen;
    logic        pause_req;
    logic        paused;
    logic        ram_req;
    logic [15:0] ram_addr;
    logic [7:0]  ram_data;
    logic        ram_ack;
    logic        timeout_err;

    int n_vec = 0;
    int n_bad = 0;
    int req_cnt = 0;
    int ack_cnt = 0;
    int pcnt = 0;
    int ack_delay = 0;
    bit ack_en = 1'b1;

    ram_upload_responder #(
        .ADDR_W(16), .REGION_BASE(16'hC000), .REGION_LEN(256),
        .UPLOAD_INDEX(8'd4), .STABLE_FRAMES(8'd60), .ACK_TIMEOUT(8'd255)
    ) dut (
        .clk_49m(clk), .reset(rst_n), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .ioctl_upload_req(ioctl_upload_req), .autosave(autosave), .vblank(vblank),
        .ram_wr_seen(ram_wr_seen), .pause_req(pause_req), .paused(paused),
        .ram_req(ram_req), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_ack(ram_ack), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: acks after ack_delay cycles of request, data = addr ^ A5.
    assign ram_ack  = ram_req && ack_en && (ack_cnt >= ack_delay);
    assign ram_data = ram_addr[7:0] ^ 8'hA5;
    always @(posedge clk) ack_cnt <= (ram_req && !ram_ack) ? ack_cnt + 1 : 0;

    // CPU model: paused follows pause_req about 5 cycles later.
    always @(posedge clk) begin
        if (!pause_req) begin
            pcnt   <= 0;
            paused <= 1'b0;
        end else begin
            if (pcnt < 5) pcnt <= pcnt + 1;
            paused <= (pcnt >= 4);
        end
    end

    always @(posedge clk) if (ioctl_upload_req) req_cnt <= req_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    // One HPS read; exp_wait < 0 skips the stall-length check.
    task automatic do_read(input logic [24:0] a, input logic [7:0] exp_d, input bit exp_fetch,
                           input logic [15:0] exp_ra, input int exp_wait);
        int waits = 0;
        bit saw_req = 1'b0;
        logic [15:0] ra = '0;
        @(posedge clk); #1;
        ioctl_rd = 1'b1;
        ioctl_addr = a;
        @(negedge clk);
        chk("rd_wait_comb", {31'd0, ioctl_wait}, 32'd1);
        @(posedge clk); #1;
        ioctl_rd = 1'b0;
        @(negedge clk);
        while (ioctl_wait && waits < 400) begin
            if (ram_req) begin
                saw_req = 1'b1;
                ra = ram_addr;
            end
            waits++;
            @(negedge clk);
        end
        chk("wait_bound", {31'd0, waits < 400}, 32'd1);
        chk("din", {24'd0, ioctl_din}, {24'd0, exp_d});
        chk("fetch", {31'd0, saw_req}, {31'd0, exp_fetch});
        if (exp_fetch) chk("ram_addr", {16'd0, ra}, {16'd0, exp_ra});
        if (exp_wait >= 0) chk("wait_cycles", waits, exp_wait);
        $display("read addr=%0d din=%02h fetch=%0d ram_addr=%04h waits=%0d", a, ioctl_din, saw_req, ra, waits);
    endtask

    task automatic wait_paused();
        int n = 0;
        while (!paused && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("paused_reached", {31'd0, paused}, 32'd1);
    endtask

    task automatic vb_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 vblank = 1'b1;
            @(posedge clk); #1 vblank = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic wr_pulse();
        @(posedge clk); #1 ram_wr_seen = 1'b1;
        @(posedge clk); #1 ram_wr_seen = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        bit stable;
        rst_n = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_addr = '0;
        ioctl_rd = 1'b0; autosave = 1'b1; vblank = 1'b0; ram_wr_seen = 1'b0;
        cycles(3);
        @(negedge clk);
        chk("rst_din", {24'd0, ioctl_din}, 32'h00);
        chk("rst_outs", {26'd0, ioctl_wait, ioctl_upload_req, pause_req, ram_req, timeout_err, |ram_addr}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Idle with nothing dirty: no autosave request.
        base = req_cnt;
        vb_pulses(100);
        chk("idle_no_req", req_cnt - base, 0);
        chk("idle_pause", {31'd0, pause_req}, 32'd0);
        $display("idle: 100 vblanks, requests=%0d", req_cnt - base);

        // Upload start; first read lands while still pausing.
        @(posedge clk); #1 ioctl_index = 8'd4; ioctl_upload = 1'b1;
        do_read(25'd0, 8'hA5, 1'b1, 16'hC000, -1);
        chk("pause_req_up", {31'd0, pause_req}, 32'd1);
        for (int a = 1; a < 256; a++)
            do_read(a[24:0], a[7:0] ^ 8'hA5, 1'b1, 16'hC000 + a[15:0], 1);
        do_read(25'd256, 8'hFF, 1'b0, 16'h0, 0);
        do_read(25'd300, 8'hFF, 1'b0, 16'h0, 0);

        // RAM never acks: timeout after ACK_TIMEOUT cycles.
        ack_en = 1'b0;
        do_read(25'd5, 8'h00, 1'b1, 16'hC005, 255);
        chk("tmo_err", {31'd0, timeout_err}, 32'd1);
        chk("tmo_req", {31'd0, ram_req}, 32'd0);
        ack_en = 1'b1;

        // End upload, timeout_err stays sticky until next start.
        @(posedge clk); #1 ioctl_upload = 1'b0;
        cycles(3);
        @(negedge clk);
        chk("end_pause", {31'd0, pause_req}, 32'd0);
        chk("end_tmo_sticky", {31'd0, timeout_err}, 32'd1);
        @(posedge clk); #1 ioctl_upload = 1'b1;
        cycles(2);
        @(negedge clk);
        chk("start_clr_tmo", {31'd0, timeout_err}, 32'd0);
        chk("start_pause", {31'd0, pause_req}, 32'd1);
        $display("timeout: err cleared on restart=%0d", !timeout_err);

        // Drop upload mid-fetch, ack 10 cycles later.
        wait_paused();
        cycles(2);
        ack_delay = 10;
        @(posedge clk); #1 ioctl_rd = 1'b1; ioctl_addr = 25'd7;
        @(posedge clk); #1 ioctl_rd = 1'b0; ioctl_upload = 1'b0;
        @(negedge clk);
        stable = 1'b1;
        n = 0;
        while (!ram_ack && n < 50) begin
            if (!ram_req || ram_addr != 16'hC007) stable = 1'b0;
            n++;
            @(negedge clk);
        end
        chk("drain_ack_seen", {31'd0, ram_ack}, 32'd1);
        chk("drain_stable", {31'd0, stable}, 32'd1);
        chk("drain_pause_hold", {31'd0, pause_req}, 32'd1);
        @(negedge clk);
        chk("drain_pause_fall", {31'd0, pause_req}, 32'd0);
        chk("drain_req_fall", {31'd0, ram_req}, 32'd0);
        cycles(3);
        @(negedge clk);
        chk("drain_idle", {30'd0, pause_req, ioctl_wait}, 32'd0);
        $display("drain: ack after %0d cycles, pause_req=%0d", n, pause_req);
        ack_delay = 0;

        // Autosave: write then 60 vblank edges -> exactly one request.
        base = req_cnt;
        wr_pulse();
        vb_pulses(59);
        chk("as_59", req_cnt - base, 0);
        vb_pulses(1);
        cycles(2);
        chk("as_60", req_cnt - base, 1);
        vb_pulses(30);
        chk("as_once", req_cnt - base, 1);
        $display("autosave: requests=%0d", req_cnt - base);

        // Write coinciding with edge 59 restarts the count.
        base = req_cnt;
        wr_pulse();
        vb_pulses(58);
        @(posedge clk); #1 vblank = 1'b1; ram_wr_seen = 1'b1;
        @(posedge clk); #1 vblank = 1'b0; ram_wr_seen = 1'b0;
        cycles(2);
        chk("as_restart0", req_cnt - base, 0);
        vb_pulses(59);
        chk("as_restart59", req_cnt - base, 0);
        vb_pulses(1);
        cycles(2);
        chk("as_restart60", req_cnt - base, 1);
        $display("autosave restart: requests=%0d", req_cnt - base);

        // autosave disabled: no request.
        base = req_cnt;
        autosave = 1'b0;
        wr_pulse();
        vb_pulses(70);
        chk("as_off", req_cnt - base, 0);
        $display("autosave off: requests=%0d", req_cnt - base);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
